// File: rtl/dsp_file_server.sv
// Responder side of the DSP file interface: NUM_FILES circular sample files in one array,
// a fixed-length file_active handshake for engine reads/writes, and a host load/flush port.
module dsp_file_server #(
    parameter int dw            = 32,
    parameter int NUM_FILES     = 4,
    parameter int DEPTH         = 16,
    parameter int ACTIVE_CYCLES = 2
) (
    input  logic          wb_clk,
    input  logic          wb_rst,
    input  logic [7:0]    file_num,
    input  logic          file_read,
    input  logic          file_write,
    input  logic [dw-1:0] file_write_data,
    output logic [dw-1:0] file_read_data,
    output logic          file_active,
    output logic [31:0]   rd_ptr,
    output logic [31:0]   wr_ptr,
    input  logic          host_wr,
    input  logic          host_flush,
    input  logic [7:0]    host_file,
    input  logic [dw-1:0] host_data,
    output logic          busy,
    output logic          overflow,
    output logic          underflow,
    output logic [1:0]    dbg_state
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int FW = (NUM_FILES > 1) ? $clog2(NUM_FILES) : 1;
    localparam int CW = $clog2(ACTIVE_CYCLES);
    localparam logic [7:0]    NF   = 8'(NUM_FILES);
    localparam logic [CW-1:0] LAST = CW'(ACTIVE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_GAP    = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [FW-1:0] cur_q, cur_d;
    logic          is_read_q, is_read_d;
    logic          fail_q, fail_d;
    logic          active_q, active_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic [dw-1:0] wdata_q, wdata_d;
    logic [dw-1:0] rdata_q, rdata_d;
    logic [PW-1:0] rd_q [NUM_FILES];
    logic [PW-1:0] rd_d [NUM_FILES];
    logic [PW-1:0] wr_q [NUM_FILES];
    logic [PW-1:0] wr_d [NUM_FILES];

    logic [dw-1:0] mem [NUM_FILES*DEPTH];
    logic          mem_we;
    logic [FW+AW-1:0] mem_waddr;
    logic [dw-1:0] mem_wdata;

    logic          host_ok, eng_ok;
    logic [FW-1:0] host_idx, eng_idx;

    assign host_ok  = host_file < NF;
    assign eng_ok   = file_num < NF;
    assign host_idx = host_file[FW-1:0];
    assign eng_idx  = file_num[FW-1:0];

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    function automatic logic is_full(input logic [PW-1:0] r, input logic [PW-1:0] w);
        return (r[AW-1:0] == w[AW-1:0]) && (r[AW] != w[AW]);
    endfunction

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cur_d     = cur_q;
        is_read_d = is_read_q;
        fail_d    = fail_q;
        active_d  = active_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        ovf_d     = 1'b0;
        unf_d     = 1'b0;
        rd_d      = rd_q;
        wr_d      = wr_q;
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        case (state_q)
            S_IDLE: begin
                // Host traffic pre-empts engines; engine requests are level-held and wait.
                if (host_flush) begin
                    if (host_ok) begin
                        rd_d[host_idx] = '0;
                        wr_d[host_idx] = '0;
                    end
                end else if (host_wr) begin
                    if (host_ok && !is_full(rd_q[host_idx], wr_q[host_idx])) begin
                        mem_we         = 1'b1;
                        mem_waddr      = {host_idx, wr_q[host_idx][AW-1:0]};
                        mem_wdata      = host_data;
                        wr_d[host_idx] = wr_q[host_idx] + PW'(1);
                    end else begin
                        ovf_d = 1'b1;
                    end
                end else if (file_read || file_write) begin
                    state_d   = S_ACTIVE;
                    active_d  = 1'b1;
                    cnt_d     = '0;
                    cur_d     = eng_idx;
                    is_read_d = file_read;
                    wdata_d   = file_write_data;
                    if (file_read) begin
                        fail_d  = !eng_ok || (rd_q[eng_idx] == wr_q[eng_idx]);
                        unf_d   = fail_d;
                        rdata_d = fail_d ? '0 : mem[{eng_idx, rd_q[eng_idx][AW-1:0]}];
                    end else begin
                        fail_d = !eng_ok || is_full(rd_q[eng_idx], wr_q[eng_idx]);
                        ovf_d  = fail_d;
                    end
                end
            end
            S_ACTIVE: begin
                if (cnt_q == LAST) begin
                    active_d = 1'b0;
                    state_d  = S_GAP;
                    if (!fail_q) begin
                        if (is_read_q) begin
                            rd_d[cur_q] = rd_q[cur_q] + PW'(1);
                        end else begin
                            mem_we      = 1'b1;
                            mem_waddr   = {cur_q, wr_q[cur_q][AW-1:0]};
                            mem_wdata   = wdata_q;
                            wr_d[cur_q] = wr_q[cur_q] + PW'(1);
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_GAP:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            cur_q     <= '0;
            is_read_q <= 1'b0;
            fail_q    <= 1'b0;
            active_q  <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            for (int i = 0; i < NUM_FILES; i++) begin
                rd_q[i] <= '0;
                wr_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cur_q     <= cur_d;
            is_read_q <= is_read_d;
            fail_q    <= fail_d;
            active_q  <= active_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
        end
    end

    // Sample storage is deliberately not reset; gating on reset aborts an in-flight commit.
    always_ff @(posedge wb_clk) begin
        if (mem_we && !wb_rst) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign file_read_data = rdata_q;
    assign file_active    = active_q;
    assign overflow       = ovf_q;
    assign underflow      = unf_q;
    assign busy           = (state_q != S_IDLE);
    assign dbg_state      = state_q;
    assign rd_ptr         = eng_ok ? 32'(rd_q[eng_idx]) : 32'd0;
    assign wr_ptr         = eng_ok ? 32'(wr_q[eng_idx]) : 32'd0;

endmodule
